// File: rtl/fence_flush_ctrl_mc_if.sv
//==============================================================================
// Module   : fence_flush_ctrl_mc_if
// Brief    : Commit/CSR event and flush-request bundle for fence_flush_ctrl_mc.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fence_flush_ctrl_mc_if #(
  parameter int unsigned NrDCaches = 1
);
  // Events from commit / CSR
  logic                 v_i;
  logic                 resolved_mispredict_i;
  logic                 fence_i;
  logic                 fence_i_i;
  logic                 sfence_vma_i;
  logic                 hfence_vvma_i;
  logic                 hfence_gvma_i;
  logic                 flush_csr_i;
  logic                 flush_commit_i;
  logic                 ex_valid_i;
  logic                 eret_i;
  logic                 set_debug_pc_i;
  logic                 halt_csr_i;
  logic [NrDCaches-1:0] flush_dcache_ack_i;
  logic                 timeout_clr_i;

  // Flush requests towards frontend, issue, EX, TLBs and caches
  logic                 set_pc_commit_o;
  logic                 flush_if_o;
  logic                 flush_unissued_instr_o;
  logic                 flush_id_o;
  logic                 flush_ex_o;
  logic                 flush_bp_o;
  logic                 flush_icache_o;
  logic                 flush_tlb_o;
  logic                 flush_tlb_vvma_o;
  logic                 flush_tlb_gvma_o;
  logic [NrDCaches-1:0] flush_dcache_o;
  logic                 halt_o;
  logic                 fence_done_o;
  logic                 timeout_o;
  logic [NrDCaches-1:0] pending_o;

  modport slave (
    input  v_i, resolved_mispredict_i, fence_i, fence_i_i, sfence_vma_i,
           hfence_vvma_i, hfence_gvma_i, flush_csr_i, flush_commit_i,
           ex_valid_i, eret_i, set_debug_pc_i, halt_csr_i,
           flush_dcache_ack_i, timeout_clr_i,
    output set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o,
           flush_ex_o, flush_bp_o, flush_icache_o, flush_tlb_o,
           flush_tlb_vvma_o, flush_tlb_gvma_o, flush_dcache_o, halt_o,
           fence_done_o, timeout_o, pending_o
  );

  modport master (
    output v_i, resolved_mispredict_i, fence_i, fence_i_i, sfence_vma_i,
           hfence_vvma_i, hfence_gvma_i, flush_csr_i, flush_commit_i,
           ex_valid_i, eret_i, set_debug_pc_i, halt_csr_i,
           flush_dcache_ack_i, timeout_clr_i,
    input  set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o,
           flush_ex_o, flush_bp_o, flush_icache_o, flush_tlb_o,
           flush_tlb_vvma_o, flush_tlb_gvma_o, flush_dcache_o, halt_o,
           fence_done_o, timeout_o, pending_o
  );
endinterface

`default_nettype wire

// File: rtl/fence_flush_ctrl_mc.sv
//==============================================================================
// Module   : fence_flush_ctrl_mc
// Brief    : Pipeline flush generator plus multi-channel D-cache fence sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fence_flush_ctrl_mc #(
  parameter int unsigned NrDCaches     = 1,
  parameter int unsigned TimeoutCycles = 0,
  parameter bit          WtDcache      = 1'b0,
  parameter bit          RVH           = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  fence_flush_ctrl_mc_if.slave    bus
);

  localparam int unsigned c_cnt_w = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last =
      c_cnt_w'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DFLUSH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e               r_state;
  logic [NrDCaches-1:0] r_pending;
  logic [NrDCaches-1:0] r_flush_dcache;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_fence_done;
  logic                 r_timeout;

  logic [NrDCaches-1:0] w_pending_next;
  logic                 w_fence_req;
  logic                 w_timeout_hit;
  logic                 w_any_fence;

  logic w_set_pc_commit, w_flush_if, w_flush_unissued, w_flush_id, w_flush_ex;
  logic w_flush_bp, w_flush_icache, w_flush_tlb, w_flush_tlb_vvma, w_flush_tlb_gvma;

  // ---------------------------------------------------------------------------
  // Combinational stage flushes; later rules override earlier ones
  // ---------------------------------------------------------------------------
  always_comb begin
    w_set_pc_commit  = 1'b0;
    w_flush_if       = 1'b0;
    w_flush_unissued = 1'b0;
    w_flush_id       = 1'b0;
    w_flush_ex       = 1'b0;
    w_flush_bp       = 1'b0;
    w_flush_icache   = 1'b0;
    w_flush_tlb      = 1'b0;
    w_flush_tlb_vvma = 1'b0;
    w_flush_tlb_gvma = 1'b0;

    w_any_fence = bus.fence_i | bus.fence_i_i | bus.sfence_vma_i
                | (RVH & bus.hfence_vvma_i) | (RVH & bus.hfence_gvma_i)
                | bus.flush_csr_i | bus.flush_commit_i;

    if (bus.resolved_mispredict_i) begin
      w_flush_unissued = 1'b1;
      w_flush_if       = 1'b1;
    end

    if (w_any_fence) begin
      w_set_pc_commit  = 1'b1;
      w_flush_if       = 1'b1;
      w_flush_unissued = 1'b1;
      w_flush_id       = 1'b1;
      w_flush_ex       = 1'b1;
    end

    if (bus.fence_i_i) begin
      w_flush_icache = 1'b1;
    end

    if (bus.sfence_vma_i) begin
      if (RVH && bus.v_i) begin
        w_flush_tlb_vvma = 1'b1;
      end else begin
        w_flush_tlb = 1'b1;
      end
    end

    if (RVH && bus.hfence_vvma_i) begin
      w_flush_tlb_vvma = 1'b1;
    end
    if (RVH && bus.hfence_gvma_i) begin
      w_flush_tlb_gvma = 1'b1;
    end

    // Trap entry/return and debug redirect the PC themselves
    if (bus.ex_valid_i || bus.eret_i || bus.set_debug_pc_i) begin
      w_flush_if       = 1'b1;
      w_flush_unissued = 1'b1;
      w_flush_id       = 1'b1;
      w_flush_ex       = 1'b1;
      w_flush_bp       = 1'b1;
      w_set_pc_commit  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // D-cache fence sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pending_next = r_pending & ~bus.flush_dcache_ack_i;
    w_fence_req    = (bus.fence_i | bus.fence_i_i) & ~WtDcache;
    w_timeout_hit  = (TimeoutCycles != 0) && (r_cnt == c_cnt_last);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_pending      <= '0;
      r_flush_dcache <= '0;
      r_cnt          <= '0;
      r_fence_done   <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_fence_done <= 1'b0;
      // A timeout set in the DFLUSH branch below overrides this clear
      if (bus.timeout_clr_i) begin
        r_timeout <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fence_req) begin
            r_state        <= ST_DFLUSH;
            r_pending      <= '1;
            r_flush_dcache <= '1;
            r_cnt          <= '0;
          end
        end

        ST_DFLUSH: begin
          if (w_pending_next == '0) begin
            r_state        <= ST_DONE;
            r_pending      <= '0;
            r_flush_dcache <= '0;
            r_fence_done   <= 1'b1;
          end else if (w_timeout_hit) begin
            r_state        <= ST_DONE;
            r_pending      <= '0;
            r_flush_dcache <= '0;
            r_fence_done   <= 1'b1;
            r_timeout      <= 1'b1;
          end else begin
            r_pending      <= w_pending_next;
            r_flush_dcache <= w_pending_next;
            r_cnt          <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state        <= ST_IDLE;
          r_pending      <= '0;
          r_flush_dcache <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.set_pc_commit_o        = w_set_pc_commit;
  assign bus.flush_if_o             = w_flush_if;
  assign bus.flush_unissued_instr_o = w_flush_unissued;
  assign bus.flush_id_o             = w_flush_id;
  assign bus.flush_ex_o             = w_flush_ex;
  assign bus.flush_bp_o             = w_flush_bp;
  assign bus.flush_icache_o         = w_flush_icache;
  assign bus.flush_tlb_o            = w_flush_tlb;
  assign bus.flush_tlb_vvma_o       = w_flush_tlb_vvma;
  assign bus.flush_tlb_gvma_o       = w_flush_tlb_gvma;
  assign bus.flush_dcache_o         = r_flush_dcache;
  assign bus.halt_o                 = bus.halt_csr_i | (r_state != ST_IDLE);
  assign bus.fence_done_o           = r_fence_done;
  assign bus.timeout_o              = r_timeout;
  assign bus.pending_o              = r_pending;

endmodule

`default_nettype wire

// File: doc/fence_flush_ctrl_mc.md
Name: fence_flush_ctrl_mc

Overview:
- Parametrised pipeline-flush and fence sequencer for cores with several write-back data caches or banks that each need a flush handshake.
- Generates the combinational front-end, ID, EX, branch-predictor and TLB flush requests from commit/CSR events.
- Runs a registered multi-channel D-cache flush FSM with per-channel sticky acknowledge tracking and an optional timeout.
- Sits between the commit/CSR stages and the frontend, issue, EX and cache subsystems.

Parameters:
NrDCaches, 1, number of D-cache flush channels (1..32)
TimeoutCycles, 0, max DFLUSH cycles before forced completion; 0 disables the timeout
WtDcache, 0, 1 = write-through D-cache; fence/fence.i never enter DFLUSH
RVH, 1, hypervisor fences enabled; 0 ties all vvma/gvma behaviour off

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
v_i  in  1  virtualisation mode
resolved_mispredict_i  in  1  branch mispredict resolved
fence_i  in  1  FENCE committed
fence_i_i  in  1  FENCE.I committed
sfence_vma_i  in  1  SFENCE.VMA committed
hfence_vvma_i  in  1  HFENCE.VVMA committed
hfence_gvma_i  in  1  HFENCE.GVMA committed
flush_csr_i  in  1  CSR side-effect flush
flush_commit_i  in  1  commit-stage flush
ex_valid_i  in  1  exception taken
eret_i  in  1  exception return
set_debug_pc_i  in  1  debug entry
halt_csr_i  in  1  WFI halt request
flush_dcache_ack_i  in  NrDCaches  per-channel flush acknowledge
timeout_clr_i  in  1  clears timeout_o
set_pc_commit_o  out  1  PC gen takes the commit PC
flush_if_o / flush_unissued_instr_o / flush_id_o / flush_ex_o / flush_bp_o  out  1 each  stage flushes
flush_icache_o  out  1  I-cache flush
flush_tlb_o / flush_tlb_vvma_o / flush_tlb_gvma_o  out  1 each  TLB flushes
flush_dcache_o  out  NrDCaches  registered per-channel D-cache flush request
halt_o  out  1  halt commit
fence_done_o  out  1  one-cycle pulse when a D-cache fence completes
timeout_o  out  1  sticky: a fence completed by timeout
pending_o  out  NrDCaches  channels not yet acknowledged (debug)

Behaviour:
- Reset: state IDLE; flush_dcache_o, pending_o, counter, fence_done_o, timeout_o all 0. Combinational outputs follow their inputs.
- Combinational flushes, all default 0, evaluated in this order with later rules overriding earlier ones:
  1. Mispredict -> flush_unissued_instr_o = 1, flush_if_o = 1.
  2. Any of fence, fence.i, sfence, hfence_vvma (RVH), hfence_gvma (RVH), flush_csr, flush_commit -> set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o, flush_ex_o = 1.
  3. fence.i -> flush_icache_o = 1 in the same cycle.
  4. sfence -> flush_tlb_vvma_o if RVH && v_i, else flush_tlb_o.
  5. hfence_vvma -> flush_tlb_vvma_o; hfence_gvma -> flush_tlb_gvma_o.
  6. ex_valid, eret or debug -> flushes if/unissued/id/ex/bp = 1 and set_pc_commit_o = 0.
- FSM states: IDLE, DFLUSH, DONE.
  - IDLE: (fence_i || fence_i_i) && !WtDcache -> DFLUSH; pending <= all ones; counter <= 0.
  - DFLUSH: pending[i] clears when ack[i] = 1. Acks on non-pending channels are ignored. Acks are sampled only in DFLUSH; an ack in the entry (IDLE) cycle is ignored.
    - pending_next == 0 -> DONE.
    - Else if TimeoutCycles != 0 and counter == TimeoutCycles-1 -> timeout_o <= 1, pending <= 0, DONE.
    - Else counter++. Counter width is $clog2(TimeoutCycles+1), minimum 1.
  - DONE: fence_done_o = 1 for this single cycle, then -> IDLE.
- flush_dcache_o[i] is registered: set to (next_state == DFLUSH) & pending_next[i]. It rises the cycle after the fence and drops the cycle after that channel's ack.
- halt_o = halt_csr_i | (state != IDLE).
- A fence arriving while not IDLE is ignored for the FSM; the combinational flushes still fire. The bench flags this with an assertion.
- timeout_o clears on timeout_clr_i. If a timeout set and timeout_clr_i occur in the same cycle, the set wins.
- Reset mid-fence returns to IDLE immediately; no done pulse is generated.

Test Plan:
- NrDCaches=2, fence at cycle 0; acks ch0 at cycle 3 and ch1 at cycle 5 -> flush_dcache_o = 2'b11 in cycles 1-3, 2'b10 in cycles 4-5, 0 from cycle 6; fence_done_o at cycle 6; halt_o high in cycles 1-6.
- NrDCaches=2, fence.i at cycle 0 with both acks at cycle 0 and again at cycle 2 -> flush_icache_o = 1 in cycle 0 only; cycle-0 acks ignored; fence_done_o at cycle 3.
- TimeoutCycles=4, fence with no ack -> DONE at cycle 5; timeout_o = 1 from cycle 5; timeout_clr_i at cycle 8 -> timeout_o = 0 at cycle 9.
- WtDcache=1, fence -> set_pc_commit_o/flush_if_o = 1 for one cycle; flush_dcache_o stays 0; halt_o never asserted; no fence_done_o.
- sfence with v_i=1 and RVH=1 -> flush_tlb_vvma_o = 1, flush_tlb_o = 0; repeat with v_i=0 -> flush_tlb_o = 1.
- ex_valid_i together with flush_commit_i -> set_pc_commit_o = 0, flush_bp_o = 1. Assert rst_ni during DFLUSH -> all registered outputs 0 asynchronously, and no fence_done_o after release.
